panel_receiver: RTL and testbench

PANEL_RECEIVER -- requirements
Module: panel_receiver

---
 rtl/types_pkg.sv | 16 +
 rtl/pixel_fifo.sv | 53 +++++
 rtl/panel_receiver.sv | 203 ++++++++++++++++++++
 tb/tb_panel_receiver.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/types_pkg.sv
// Shared types for the panel receiver: RGB565 pixel and capture state encoding.
package types_pkg;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    typedef enum logic [1:0] {
        WAIT_VSYNC = 2'd0,
        WAIT_LINE  = 2'd1,
        IN_LINE    = 2'd2
    } rx_state_t;

endpackage

// File: rtl/pixel_fifo.sv
// Count-based pixel FIFO with a combinational read port, so an entry is visible the cycle after push.
module pixel_fifo #(
    parameter int WIDTH = 22,
    parameter int DEPTH = 4
) (
    input  logic             clk_pix,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             valid,
    output logic [WIDTH-1:0] pop_data,
    output logic             drop
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             full;
    logic             pop_ok;
    logic             push_ok;

    assign full     = (count == (AW+1)'(DEPTH));
    assign valid    = (count != '0);
    assign pop_ok   = pop && valid;
    // A pop frees the slot in the same edge, so a full FIFO still accepts the push.
    assign push_ok  = push && (!full || pop_ok);
    assign drop     = push && full && !pop_ok;
    assign pop_data = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk_pix) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk_pix) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/panel_receiver.sv
// RGB565 parallel panel receiver: frames de/vsync into a pixel stream with coordinates and lock/error status.
//   state      | meaning
//   WAIT_VSYNC | unsynchronised or display disabled; de ignored until a vsync edge
//   WAIT_LINE  | inside a frame, between lines
//   IN_LINE    | de active, capturing pixels of the current line
import types_pkg::*;

module panel_receiver #(
    parameter int H_ACTIVE        = 800,
    parameter int V_ACTIVE        = 480,
    parameter int SYNC_ACTIVE_LOW = 1,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                        clk_pix,
    input  logic                        rstn,
    input  logic                        disp_en,
    input  logic                        hsync,
    input  logic                        vsync,
    input  logic                        de,
    input  logic [4:0]                  r,
    input  logic [5:0]                  g,
    input  logic [4:0]                  b,
    output logic                        pix_m_valid,
    input  logic                        pix_m_ready,
    output logic [15:0]                 pix_m_data,
    output logic [$clog2(H_ACTIVE)-1:0] pix_m_x,
    output logic [$clog2(V_ACTIVE)-1:0] pix_m_y,
    output logic                        pix_m_sof,
    output logic                        pix_m_eol,
    output logic                        frame_done,
    output logic [15:0]                 frame_count,
    output logic                        locked,
    output logic                        line_err,
    output logic                        frame_err,
    output logic                        overflow,
    input  logic                        err_clear
);
    localparam int XOW = $clog2(H_ACTIVE);
    localparam int YOW = $clog2(V_ACTIVE);
    localparam int XW  = $clog2(H_ACTIVE + 1);
    localparam int YW  = $clog2(V_ACTIVE + 1);
    localparam int PW  = 16 + XOW + YOW + 2;
    localparam logic [XW-1:0] H_MAX  = XW'(H_ACTIVE);
    localparam logic [XW-1:0] H_LAST = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] V_MAX  = YW'(V_ACTIVE);

    logic    en_q, vs_q, vs_prev, de_q, clr_q, hsync_q;
    rgb565_t rgb_q;
    logic    vs_edge;
    logic    hsync_unused;

    rx_state_t     state, state_next;
    logic [XW-1:0] x, x_next;
    logic [YW-1:0] y, y_next, y_end;
    logic          push, line_ev, frame_ev, eof, frame_start;
    logic          drop, err_any, frame_bad;
    logic [PW-1:0] cap_data, fifo_q;

    // vs_q holds vsync normalised to active-high.
    always_ff @(posedge clk_pix) begin
        if (!rstn) begin
            en_q    <= 1'b0;
            vs_q    <= 1'b0;
            vs_prev <= 1'b0;
            de_q    <= 1'b0;
            clr_q   <= 1'b0;
            hsync_q <= 1'b0;
            rgb_q   <= '0;
        end else begin
            en_q    <= disp_en;
            vs_q    <= (SYNC_ACTIVE_LOW != 0) ? ~vsync : vsync;
            vs_prev <= vs_q;
            de_q    <= de;
            clr_q   <= err_clear;
            hsync_q <= hsync;
            rgb_q   <= '{r: r, g: g, b: b};
        end
    end

    // Line framing is taken from de alone; hsync is sampled but not needed.
    assign hsync_unused = hsync_q;
    assign vs_edge      = vs_q && !vs_prev;
    assign y_end        = (y < V_MAX) ? y + 1'b1 : y;

    always_comb begin
        state_next  = state;
        x_next      = x;
        y_next      = y;
        push        = 1'b0;
        line_ev     = 1'b0;
        frame_ev    = 1'b0;
        eof         = 1'b0;
        frame_start = 1'b0;
        if (!en_q) begin
            state_next = WAIT_VSYNC;
            x_next     = '0;
            y_next     = '0;
        end else begin
            case (state)
                WAIT_VSYNC: begin
                    if (vs_edge) begin
                        state_next  = WAIT_LINE;
                        x_next      = '0;
                        y_next      = '0;
                        frame_start = 1'b1;
                    end
                end
                WAIT_LINE: begin
                    if (vs_edge) begin
                        x_next      = '0;
                        y_next      = '0;
                        frame_start = 1'b1;
                        if (y != '0) begin
                            eof      = 1'b1;
                            frame_ev = (y != V_MAX);
                        end
                    end else if (de_q) begin
                        state_next = IN_LINE;
                        x_next     = XW'(1);
                        push       = (y < V_MAX);
                        frame_ev   = (y >= V_MAX);
                    end
                end
                IN_LINE: begin
                    if (vs_edge || !de_q) begin
                        state_next = WAIT_LINE;
                        x_next     = '0;
                        line_ev    = (x != H_MAX);
                        y_next     = y_end;
                        if (vs_edge) begin
                            eof         = 1'b1;
                            frame_ev    = (y_end != V_MAX);
                            y_next      = '0;
                            frame_start = 1'b1;
                        end
                    end else begin
                        push     = (x < H_MAX) && (y < V_MAX);
                        line_ev  = (x >= H_MAX);
                        frame_ev = (y >= V_MAX);
                        x_next   = (x < H_MAX) ? x + 1'b1 : x;
                    end
                end
                default: begin
                    state_next = WAIT_VSYNC;
                    x_next     = '0;
                    y_next     = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_pix) begin
        if (!rstn) begin
            state <= WAIT_VSYNC;
            x     <= '0;
            y     <= '0;
        end else begin
            state <= state_next;
            x     <= x_next;
            y     <= y_next;
        end
    end

    assign cap_data = {rgb_q, x[XOW-1:0], y[YOW-1:0],
                       (x == '0) && (y == '0), (x == H_LAST)};

    pixel_fifo #(.WIDTH(PW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_pix  (clk_pix),
        .rstn     (rstn),
        .push     (push),
        .push_data(cap_data),
        .pop      (pix_m_ready),
        .valid    (pix_m_valid),
        .pop_data (fifo_q),
        .drop     (drop)
    );

    assign {pix_m_data, pix_m_x, pix_m_y, pix_m_sof, pix_m_eol} = fifo_q;
    assign err_any = line_ev || frame_ev || drop;

    always_ff @(posedge clk_pix) begin
        if (!rstn) begin
            frame_done  <= 1'b0;
            frame_count <= '0;
            locked      <= 1'b0;
            frame_bad   <= 1'b0;
            line_err    <= 1'b0;
            frame_err   <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            frame_done  <= eof;
            frame_count <= frame_count + 16'(eof);
            frame_bad   <= frame_start ? 1'b0 : (frame_bad || err_any);
            if (!en_q || err_any)     locked <= 1'b0;
            else if (eof && !frame_bad) locked <= 1'b1;
            // A new error in the clearing cycle wins.
            line_err  <= line_ev  || (line_err  && !clr_q);
            frame_err <= frame_ev || (frame_err && !clr_q);
            overflow  <= drop     || (overflow  && !clr_q);
        end
    end

endmodule

// File: tb/tb_panel_receiver.sv
// Directed bench for panel_receiver at 4x3 active, depth-4 FIFO, low-active sync.
module tb_panel_receiver;

    logic        clk_pix = 1'b0;
    logic        rstn, disp_en, hsync, vsync, de;
    logic [4:0]  r;
    logic [5:0]  g;
    logic [4:0]  b;
    logic        pix_m_valid, pix_m_ready;
    logic [15:0] pix_m_data;
    logic [1:0]  pix_m_x, pix_m_y;
    logic        pix_m_sof, pix_m_eol, frame_done;
    logic [15:0] frame_count;
    logic        locked, line_err, frame_err, overflow, err_clear;

    int total = 0;
    int bad   = 0;
    int fd_cnt = 0;

    typedef struct packed {
        logic [15:0] d;
        logic [1:0]  x;
        logic [1:0]  y;
        logic        sof;
        logic        eol;
    } beat_t;
    beat_t beats[$];

    always #5 clk_pix = ~clk_pix;

    panel_receiver #(
        .H_ACTIVE(4), .V_ACTIVE(3), .SYNC_ACTIVE_LOW(1), .FIFO_DEPTH(4)
    ) dut (
        .clk_pix(clk_pix), .rstn(rstn), .disp_en(disp_en), .hsync(hsync),
        .vsync(vsync), .de(de), .r(r), .g(g), .b(b),
        .pix_m_valid(pix_m_valid), .pix_m_ready(pix_m_ready),
        .pix_m_data(pix_m_data), .pix_m_x(pix_m_x), .pix_m_y(pix_m_y),
        .pix_m_sof(pix_m_sof), .pix_m_eol(pix_m_eol),
        .frame_done(frame_done), .frame_count(frame_count), .locked(locked),
        .line_err(line_err), .frame_err(frame_err), .overflow(overflow),
        .err_clear(err_clear)
    );

    always @(negedge clk_pix) begin
        if (pix_m_valid && pix_m_ready)
            beats.push_back('{d: pix_m_data, x: pix_m_x, y: pix_m_y,
                              sof: pix_m_sof, eol: pix_m_eol});
        if (frame_done) fd_cnt++;
    end

    function automatic logic [15:0] exp_pix(input int l, input int p);
        logic [4:0] rr;
        logic [5:0] gg;
        rr = 5'(l);
        gg = 6'(p);
        return {rr, gg, 5'd3};
    endfunction

    function automatic beat_t exp_beat(input int l, input int p);
        return '{d: exp_pix(l, p), x: 2'(p), y: 2'(l),
                 sof: (l == 0 && p == 0), eol: (p == 3)};
    endfunction

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk_pix);
            #1;
        end
    endtask

    task automatic drive_line(input int line, input int npix);
        for (int p = 0; p < npix; p++) begin
            de = 1'b1;
            r  = 5'(line);
            g  = 6'(p);
            b  = 5'd3;
            cyc(1);
        end
        de = 1'b0;
        cyc(2);
    endtask

    task automatic vsync_pulse();
        vsync = 1'b0;
        cyc(1);
        vsync = 1'b1;
        cyc(2);
    endtask

    task automatic clear_errs();
        err_clear = 1'b1;
        cyc(1);
        err_clear = 1'b0;
        cyc(3);
    endtask

    task automatic test_reset();
        total++;
        if ({pix_m_valid, pix_m_data, pix_m_x, pix_m_y, pix_m_sof, pix_m_eol} !== 22'd0) begin
            bad++;
            $display("FAIL reset_stream: got valid=%b data=%h x=%0d y=%0d sof=%b eol=%b want all 0",
                     pix_m_valid, pix_m_data, pix_m_x, pix_m_y, pix_m_sof, pix_m_eol);
        end
        total++;
        if ({frame_done, frame_count, locked, line_err, frame_err, overflow} !== 21'd0) begin
            bad++;
            $display("FAIL reset_status: got fd=%b cnt=%0d lock=%b le=%b fe=%b ov=%b want all 0",
                     frame_done, frame_count, locked, line_err, frame_err, overflow);
        end
    endtask

    task automatic test_clean_frame();
        int fd0;
        beats.delete();
        fd0 = fd_cnt;
        vsync_pulse();
        for (int l = 0; l < 3; l++) drive_line(l, 4);
        vsync_pulse();
        cyc(4);
        total++;
        if (beats.size() !== 12) begin
            bad++;
            $display("FAIL clean_beats: got %0d want 12", beats.size());
        end
        for (int i = 0; i < beats.size() && i < 12; i++) begin
            total++;
            if (beats[i] !== exp_beat(i / 4, i % 4)) begin
                bad++;
                $display("FAIL clean_beat%0d: got %h want %h", i, beats[i], exp_beat(i / 4, i % 4));
            end
        end
        total++;
        if (fd_cnt - fd0 !== 1) begin
            bad++;
            $display("FAIL clean_frame_done: got %0d pulses want 1", fd_cnt - fd0);
        end
        total++;
        if (frame_count !== 16'd1) begin
            bad++;
            $display("FAIL clean_count: got %0d want 1", frame_count);
        end
        total++;
        if ({locked, line_err, frame_err, overflow} !== 4'b1000) begin
            bad++;
            $display("FAIL clean_status: got lock/le/fe/ov=%b want 1000",
                     {locked, line_err, frame_err, overflow});
        end
    endtask

    task automatic test_long_line();
        int fd0;
        beats.delete();
        fd0 = fd_cnt;
        drive_line(0, 5);
        drive_line(1, 4);
        drive_line(2, 4);
        vsync_pulse();
        cyc(4);
        total++;
        if (beats.size() !== 12) begin
            bad++;
            $display("FAIL long_beats: got %0d want 12", beats.size());
        end
        total++;
        if (beats.size() > 4 && beats[4] !== exp_beat(1, 0)) begin
            bad++;
            $display("FAIL long_beat4: got %h want %h", beats[4], exp_beat(1, 0));
        end
        total++;
        if ({locked, line_err, frame_err, overflow} !== 4'b0100) begin
            bad++;
            $display("FAIL long_status: got lock/le/fe/ov=%b want 0100",
                     {locked, line_err, frame_err, overflow});
        end
        total++;
        if (frame_count !== 16'd2 || fd_cnt - fd0 !== 1) begin
            bad++;
            $display("FAIL long_count: got cnt=%0d pulses=%0d want 2 and 1", frame_count, fd_cnt - fd0);
        end
        clear_errs();
        total++;
        if (line_err !== 1'b0) begin
            bad++;
            $display("FAIL long_clear: got line_err=%b want 0", line_err);
        end
    endtask

    task automatic test_short_frame();
        int fd0;
        beats.delete();
        fd0 = fd_cnt;
        drive_line(0, 4);
        drive_line(1, 4);
        vsync_pulse();
        cyc(4);
        total++;
        if ({frame_err, line_err} !== 2'b10) begin
            bad++;
            $display("FAIL short_err: got fe/le=%b want 10", {frame_err, line_err});
        end
        total++;
        if (frame_count !== 16'd3 || fd_cnt - fd0 !== 1) begin
            bad++;
            $display("FAIL short_count: got cnt=%0d pulses=%0d want 3 and 1", frame_count, fd_cnt - fd0);
        end
        total++;
        if (beats.size() !== 8) begin
            bad++;
            $display("FAIL short_beats: got %0d want 8", beats.size());
        end
        clear_errs();
    endtask

    task automatic test_overflow();
        beats.delete();
        pix_m_ready = 1'b0;
        for (int l = 0; l < 3; l++) begin
            drive_line(l, 4);
            @(negedge clk_pix);
            total++;
            if ({pix_m_valid, pix_m_data, pix_m_x, pix_m_y, pix_m_sof, pix_m_eol} !==
                {1'b1, exp_pix(0, 0), 2'd0, 2'd0, 1'b1, 1'b0}) begin
                bad++;
                $display("FAIL ovf_hold%0d: got valid=%b data=%h x=%0d y=%0d sof=%b want 1 %h 0 0 1",
                         l, pix_m_valid, pix_m_data, pix_m_x, pix_m_y, pix_m_sof, exp_pix(0, 0));
            end
            @(posedge clk_pix);
            #1;
        end
        vsync_pulse();
        total++;
        if (overflow !== 1'b1) begin
            bad++;
            $display("FAIL ovf_flag: got %b want 1", overflow);
        end
        pix_m_ready = 1'b1;
        cyc(8);
        total++;
        if (beats.size() !== 4) begin
            bad++;
            $display("FAIL ovf_drain: got %0d beats want 4", beats.size());
        end
        for (int i = 0; i < beats.size() && i < 4; i++) begin
            total++;
            if (beats[i] !== exp_beat(0, i)) begin
                bad++;
                $display("FAIL ovf_beat%0d: got %h want %h", i, beats[i], exp_beat(0, i));
            end
        end
        clear_errs();
    endtask

    task automatic test_reset_midline();
        int nb;
        beats.delete();
        drive_line(0, 4);
        for (int p = 0; p < 2; p++) begin
            de = 1'b1;
            r  = 5'd1;
            g  = 6'(p);
            cyc(1);
        end
        rstn = 1'b0;
        g    = 6'd2;
        cyc(1);
        rstn = 1'b1;
        test_reset();
        nb = beats.size();
        g  = 6'd3;
        cyc(1);
        de = 1'b0;
        cyc(2);
        drive_line(2, 4);
        cyc(4);
        total++;
        if (beats.size() !== nb) begin
            bad++;
            $display("FAIL rst_no_beats: got %0d beats want %0d", beats.size(), nb);
        end
        vsync_pulse();
        drive_line(0, 4);
        cyc(4);
        total++;
        if (beats.size() !== nb + 4) begin
            bad++;
            $display("FAIL rst_resume: got %0d beats want %0d", beats.size(), nb + 4);
        end
        total++;
        if (beats.size() > nb && beats[nb] !== exp_beat(0, 0)) begin
            bad++;
            $display("FAIL rst_first: got %h want %h", beats[nb], exp_beat(0, 0));
        end
    endtask

    task automatic test_disp_en();
        vsync_pulse();
        for (int l = 0; l < 3; l++) drive_line(l, 4);
        vsync_pulse();
        cyc(2);
        total++;
        if (locked !== 1'b1) begin
            bad++;
            $display("FAIL den_locked: got %b want 1", locked);
        end
        beats.delete();
        pix_m_ready = 1'b0;
        for (int p = 0; p < 4; p++) begin
            if (p == 2) disp_en = 1'b0;
            de = 1'b1;
            r  = 5'd0;
            g  = 6'(p);
            cyc(1);
        end
        de = 1'b0;
        cyc(3);
        total++;
        if (locked !== 1'b0) begin
            bad++;
            $display("FAIL den_unlock: got %b want 0", locked);
        end
        drive_line(1, 4);
        pix_m_ready = 1'b1;
        cyc(6);
        total++;
        if (beats.size() !== 2) begin
            bad++;
            $display("FAIL den_drain: got %0d beats want 2", beats.size());
        end
        for (int i = 0; i < beats.size() && i < 2; i++) begin
            total++;
            if (beats[i] !== exp_beat(0, i)) begin
                bad++;
                $display("FAIL den_beat%0d: got %h want %h", i, beats[i], exp_beat(0, i));
            end
        end
        disp_en = 1'b1;
        cyc(2);
        drive_line(0, 4);
        cyc(4);
        total++;
        if (beats.size() !== 2) begin
            bad++;
            $display("FAIL den_no_vsync: got %0d beats want 2", beats.size());
        end
        vsync_pulse();
        drive_line(0, 4);
        cyc(4);
        total++;
        if (beats.size() !== 6) begin
            bad++;
            $display("FAIL den_resume: got %0d beats want 6", beats.size());
        end
        total++;
        if (beats.size() > 2 && beats[2] !== exp_beat(0, 0)) begin
            bad++;
            $display("FAIL den_resume_sof: got %h want %h", beats[2], exp_beat(0, 0));
        end
    endtask

    initial begin
        rstn        = 1'b0;
        disp_en     = 1'b1;
        hsync       = 1'b1;
        vsync       = 1'b1;
        de          = 1'b0;
        r           = '0;
        g           = '0;
        b           = 5'd3;
        pix_m_ready = 1'b1;
        err_clear   = 1'b0;
        cyc(3);
        test_reset();
        rstn = 1'b1;
        cyc(2);
        test_clean_frame();
        test_long_line();
        test_short_frame();
        test_overflow();
        test_reset_midline();
        test_disp_en();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
